// File: rtl/stream_mux_n_to_1.sv
// stream_mux_n_to_1: NUM_IN:1 registered stream multiplexor with per-channel
// valid/ready handshake and burst locking. One output register stage.
// Optional build macro STREAM_MUX_RR_EN: round-robin channel selection in IDLE
// (sel ignored); without it the channel comes straight from sel.
module stream_mux_n_to_1 #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned WIDTH  = 8,
    // Derived from NUM_IN; leave at its default.
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_IN-1:0]         in_valid,
    input  logic [NUM_IN-1:0]         in_last,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    output logic [NUM_IN-1:0]         in_ready,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             rr_found;
    logic             unused_sel;
    assign unused_sel = ^sel;
`endif

    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic [SEL_W-1:0] cur;
    logic             cur_ok;
    logic             cur_valid;
    logic             cur_last;
    logic [WIDTH-1:0] cur_data;
    logic             space;
    logic             accept;

    // Channel choice: locked channel mid-burst, otherwise sel (or round-robin scan).
    always_comb begin
        cur    = '0;
        cur_ok = 1'b0;
`ifdef STREAM_MUX_RR_EN
        rr_found = 1'b0;
`endif
        if (state_q == LOCKED) begin
            cur    = lock_sel_q;
            cur_ok = 1'b1;
        end else begin
`ifdef STREAM_MUX_RR_EN
            // Two passes replace a modulo scan: first from rr_ptr upward, then
            // from 0, which only yields a hit below rr_ptr if the first found none.
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (!rr_found && in_valid[i] && (i >= 32'(rr_ptr_q))) begin
                    rr_found = 1'b1;
                    cur      = SEL_W'(i);
                end
            end
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (!rr_found && in_valid[i]) begin
                    rr_found = 1'b1;
                    cur      = SEL_W'(i);
                end
            end
            cur_ok = rr_found;
`else
            cur    = sel;
            cur_ok = (32'(sel) < NUM_IN);
`endif
        end
    end

    // Fetch the handshake and payload of the chosen channel.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (cur_ok && (SEL_W'(i) == cur)) begin
                cur_valid = in_valid[i];
                cur_last  = in_last[i];
                cur_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
`ifdef STREAM_MUX_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
`ifdef STREAM_MUX_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // FSM next state: lock on the first beat of a multi-beat burst, unlock on its last beat.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
`ifdef STREAM_MUX_RR_EN
        rr_ptr_d   = rr_ptr_q;
        if (accept && cur_last) begin
            rr_ptr_d = (32'(cur) + 32'd1 >= NUM_IN) ? '0 : cur + 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (accept && !cur_last) begin
                    state_d    = LOCKED;
                    lock_sel_d = cur;
                end
            end
            LOCKED: begin
                if (accept && cur_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: per-channel ready and the accept strobe, both gated by reset.
    always_comb begin
        space  = !out_valid_q || out_ready;
        accept = reset_n && cur_ok && space && cur_valid;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            in_ready[i] = reset_n && cur_ok && space && (SEL_W'(i) == cur);
        end
    end

    // Output register next state: load on accept, drain when taken, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = cur_last;
            out_data_d  = cur_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule
